// File: rtl/tow_scorer.sv
// rtl/tow_scorer.sv - tug-of-war rope-position scorer: tracks the rope, detects wins and false starts,
// drives the LED bar and the per-player round tallies.
module tow_scorer #(
  parameter int N_POS   = 9,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               leds_on,
  input  logic [1:0]         led_control,
  input  logic               pbl,
  input  logic               pbr,
  output logic [N_POS-1:0]   leds,
  output logic               winrnd,
  output logic               winner,
  output logic               win_vld,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r
);

  localparam int PW = $clog2(N_POS);
  localparam logic [PW-1:0] CENTRE = PW'((N_POS - 1) / 2);
  localparam logic [PW-1:0] NEAR_R = PW'(N_POS - 2);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;
  localparam logic [SCORE_W-1:0] S_ONE = SCORE_W'(1);

  logic [PW-1:0]      pos, pos_n;
  logic               armed, armed_n;
  logic               was_dark;
  logic               win_pend;
  logic               win_vld_n, winner_n, win_evt;
  logic [SCORE_W-1:0] score_l_n, score_r_n;
  logic [N_POS-1:0]   leds_n;

  logic dark, play, single_l, single_r;
  assign dark     = !leds_on && !clear;
  assign play     = leds_on && !clear;
  assign single_l = pbl && !pbr;
  assign single_r = pbr && !pbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= CENTRE;
      armed    <= 1'b0;
      was_dark <= 1'b0;
      win_pend <= 1'b0;
      winrnd   <= 1'b0;
      win_vld  <= 1'b0;
      winner   <= 1'b0;
      score_l  <= '0;
      score_r  <= '0;
      leds     <= '1;
    end else begin
      pos      <= pos_n;
      armed    <= armed_n;
      was_dark <= dark;
      win_pend <= win_evt;
      winrnd   <= win_pend;
      win_vld  <= win_vld_n;
      winner   <= winner_n;
      score_l  <= score_l_n;
      score_r  <= score_r_n;
      leds     <= leds_n;
    end
  end

  always_comb begin
    pos_n     = pos;
    armed_n   = armed;
    win_vld_n = win_vld;
    winner_n  = winner;
    score_l_n = score_l;
    score_r_n = score_r;
    win_evt   = 1'b0;
    if (clear) begin
      armed_n = 1'b0;
      if (!win_vld) pos_n = CENTRE;
    end else if (dark && !was_dark) begin
      win_vld_n = 1'b0;
      pos_n     = CENTRE;
      armed_n   = 1'b1;
    end else if (armed && dark && (single_l || single_r)) begin
      // false start: the player who did not press takes the round
      win_evt  = 1'b1;
      winner_n = single_l;
    end else if (armed && play) begin
      if (single_l) begin
        pos_n = pos - P_ONE;
        if (pos == P_ONE) begin
          win_evt  = 1'b1;
          winner_n = 1'b0;
        end
      end else if (single_r) begin
        pos_n = pos + P_ONE;
        if (pos == NEAR_R) begin
          win_evt  = 1'b1;
          winner_n = 1'b1;
        end
      end
    end
    if (win_evt) begin
      armed_n   = 1'b0;
      win_vld_n = 1'b1;
      if (winner_n) score_r_n = (score_r == S_MAX) ? score_r : score_r + S_ONE;
      else          score_l_n = (score_l == S_MAX) ? score_l : score_l + S_ONE;
    end
  end

  // bar follows the state being registered this edge so leds never lag pos
  always_comb begin
    leds_n = '0;
    if (led_control[0]) begin
      leds_n = '1;
    end else if (!leds_on || !led_control[1]) begin
      leds_n = '0;
    end else if (win_vld_n) begin
      if (winner_n) leds_n[N_POS-1] = 1'b1;
      else          leds_n[0]       = 1'b1;
    end else begin
      leds_n[pos_n] = 1'b1;
    end
  end

endmodule

// File: tb/tb_tow_scorer.sv
// tb/tb_tow_scorer.sv - randomized and directed bench for tow_scorer against a behavioural model.
module tb_tow_scorer;

  localparam int N = 9;
  localparam int C = (N - 1) / 2;
  localparam int SMAX = 15;

  logic       clk, rst, clear, leds_on, pbl, pbr;
  logic [1:0] led_control;
  logic [N-1:0] leds;
  logic       winrnd, winner, win_vld;
  logic [3:0] score_l, score_r;

  tow_scorer #(.N_POS(N), .SCORE_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .leds_on(leds_on), .led_control(led_control),
    .pbl(pbl), .pbr(pbr), .leds(leds), .winrnd(winrnd), .winner(winner),
    .win_vld(win_vld), .score_l(score_l), .score_r(score_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_pos, m_sl, m_sr;
  bit m_armed, m_won, m_winner, m_pend, m_rnd, m_was_dark;
  logic [N-1:0] m_leds;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = C; m_sl = 0; m_sr = 0;
    m_armed = 0; m_won = 0; m_winner = 0; m_pend = 0; m_rnd = 0; m_was_dark = 0;
    m_leds = '1;
  endtask

  task automatic award(input bit w);
    m_won = 1; m_winner = w; m_armed = 0; m_pend = 1;
    if (w) m_sr = (m_sr >= SMAX) ? SMAX : m_sr + 1;
    else   m_sl = (m_sl >= SMAX) ? SMAX : m_sl + 1;
  endtask

  task automatic model_step();
    bit dark, play, sl, sr;
    dark = !leds_on && !clear;
    play = leds_on && !clear;
    sl = pbl && !pbr;
    sr = pbr && !pbl;
    m_rnd = m_pend;
    m_pend = 0;
    if (clear) begin
      m_armed = 0;
      if (!m_won) m_pos = C;
    end else if (dark && !m_was_dark) begin
      m_won = 0; m_pos = C; m_armed = 1;
    end else if (dark && m_armed && (sl || sr)) begin
      award(sl);
    end else if (play && m_armed && (sl || sr)) begin
      m_pos = m_pos + (sr ? 1 : -1);
      if (m_pos == 0) award(0);
      else if (m_pos == N - 1) award(1);
    end
    m_was_dark = dark;
    if (led_control[0]) m_leds = '1;
    else if (!leds_on || !led_control[1]) m_leds = '0;
    else if (m_won) m_leds = m_winner ? (N)'(1 << (N - 1)) : (N)'(1);
    else m_leds = (N)'(1 << m_pos);
  endtask

  task automatic check_all();
    check("leds", 32'(leds), 32'(m_leds));
    check("winrnd", 32'(winrnd), 32'(m_rnd));
    check("win_vld", 32'(win_vld), 32'(m_won));
    if (m_won) check("winner", 32'(winner), 32'(m_winner));
    check("score_l", 32'(score_l), 32'(m_sl));
    check("score_r", 32'(score_r), 32'(m_sr));
  endtask

  task automatic cyc(input bit l, input bit r);
    pbl = l; pbr = r;
    @(posedge clk);
    model_step();
    #1;
    pbl = 0; pbr = 0;
    check_all();
  endtask

  task automatic idle_phase(input int n);
    clear = 1; leds_on = 0; led_control = 2'b10;
    repeat (n) cyc(0, 0);
  endtask

  task automatic dark_phase(input int n);
    clear = 0; leds_on = 0; led_control = 2'b00;
    repeat (n) cyc(0, 0);
  endtask

  task automatic play_phase();
    clear = 0; leds_on = 1; led_control = 2'b10;
  endtask

  function automatic bit chance(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin
    rst = 1; clear = 1; leds_on = 0; led_control = 2'b01; pbl = 0; pbr = 0;
    model_reset();
    #7;
    check("reset_leds", 32'(leds), 32'h1FF);
    check("reset_score_l", 32'(score_l), 0);
    check("reset_win_vld", 32'(win_vld), 0);
    check_all();
    rst = 0;
    repeat (3) cyc(0, 0);

    // right player pulls four times to the right end
    dark_phase(3);
    play_phase();
    repeat (4) begin cyc(0, 1); cyc(0, 0); end
    check("t2_leds", 32'(leds), 32'h100);
    check("t2_score_r", 32'(score_r), 1);
    repeat (4) begin cyc(1, 0); cyc(0, 1); end

    // false start by the left player
    idle_phase(2);
    dark_phase(2);
    cyc(1, 0);
    repeat (3) cyc(0, 0);
    check("t3_score_r", 32'(score_r), 2);
    check("t3_score_l", 32'(score_l), 0);

    // simultaneous presses cancel
    idle_phase(2);
    dark_phase(2);
    play_phase();
    repeat (5) cyc(1, 1);
    check("t4_leds", 32'(leds), 32'h010);

    // tally saturation
    repeat (16) begin
      idle_phase(2);
      dark_phase(2);
      play_phase();
      repeat (4) cyc(0, 1);
      cyc(0, 0);
    end
    check("t5_score_r_sat", 32'(score_r), 15);

    // asynchronous reset in the middle of a round
    idle_phase(2);
    dark_phase(2);
    play_phase();
    cyc(0, 1); cyc(0, 1);
    led_control = 2'b00;
    #3 rst = 1;
    #1;
    model_reset();
    check("t6_leds", 32'(leds), 32'h1FF);
    check("t6_score_r", 32'(score_r), 0);
    check("t6_win_vld", 32'(win_vld), 0);
    check("t6_winrnd", 32'(winrnd), 0);
    #2 rst = 0;
    dark_phase(2);
    play_phase();
    cyc(0, 1);

    // randomized rounds
    for (int rnd = 0; rnd < 60; rnd++) begin
      clear = 1; leds_on = 1'($urandom_range(0, 1));
      led_control = chance(15) ? 2'b01 : 2'b10;
      repeat ($urandom_range(1, 3)) cyc(chance(30), chance(30));
      clear = 0; leds_on = 0;
      led_control = chance(15) ? 2'b01 : 2'b00;
      repeat ($urandom_range(2, 6)) cyc(chance(10), chance(10));
      play_phase();
      if (chance(15)) led_control = 2'b11;
      repeat ($urandom_range(5, 35)) cyc(chance(45), chance(45));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
